// File: rtl/bist_ram_pkg.sv
// Shared types and March C- element tables for the self-testing RAM.
// Element tables are indexed by element number: bit i describes element Ei.
package bist_ram_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrOnly,
    StRd,
    StRdCmpWr,
    StRdCmp,
    StDone
  } state_t;

  localparam int unsigned MARCH_LEN = 6;

  localparam logic [2:0] E0 = 3'd0;
  localparam logic [2:0] E1 = 3'd1;
  localparam logic [2:0] E2 = 3'd2;
  localparam logic [2:0] E3 = 3'd3;
  localparam logic [2:0] E4 = 3'd4;
  localparam logic [2:0] E5 = 3'd5;

  localparam logic [MARCH_LEN-1:0] ELEM_DOWN    = 6'b011000;
  localparam logic [MARCH_LEN-1:0] ELEM_EXP_ONE = 6'b010100;
  localparam logic [MARCH_LEN-1:0] ELEM_WR_ONE  = 6'b001010;

  function automatic logic elem_down(input logic [2:0] e);
    return ELEM_DOWN[e];
  endfunction

  function automatic logic elem_exp_one(input logic [2:0] e);
    return ELEM_EXP_ONE[e];
  endfunction

  function automatic logic elem_wr_one(input logic [2:0] e);
    return ELEM_WR_ONE[e];
  endfunction

endpackage

// File: rtl/bist_ram_sp_ram.sv
// Single-port RAM with registered, read-before-write output.
// Out-of-range addresses drop writes and read back zero.
module sp_ram #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned WIDTH  = 2,
  parameter int unsigned AWIDTH = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AWIDTH-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic                        in_range;

  assign in_range = 32'(addr) < DEPTH;

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we && in_range) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (in_range) begin
      rdata <= mem[addr];
    end else begin
      rdata <= '0;
    end
  end

endmodule

// File: rtl/bist_ram.sv
// Single-port RAM with an integrated March C- self-test controller.
// While the test runs the controller owns the RAM port; otherwise the functional port does.
module bist_ram
  import bist_ram_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned WIDTH  = 2,
  parameter int unsigned AWIDTH = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic [AWIDTH-1:0] addr,
  input  logic [WIDTH-1:0]  din,
  output logic [WIDTH-1:0]  dout,
  input  logic              bist_start,
  output logic              bist_busy,
  output logic              bist_done,
  output logic              bist_fail,
  output logic [AWIDTH-1:0] fail_addr,
  output logic [2:0]        fail_elem
);

  localparam logic [AWIDTH-1:0] LAST = AWIDTH'(DEPTH - 1);

  state_t            state_q;
  logic [2:0]        elem_q;
  logic [AWIDTH-1:0] cnt_q;

  logic              active, cur_down, term, mismatch;
  logic [2:0]        elem_nxt;
  logic [WIDTH-1:0]  exp_w, wr_w;
  logic              ram_we;
  logic [AWIDTH-1:0] ram_addr;
  logic [WIDTH-1:0]  ram_wdata;

  always_comb begin
    active   = (state_q != StIdle) && (state_q != StDone);
    cur_down = elem_down(elem_q);
    elem_nxt = elem_q + 3'd1;
    term     = cur_down ? (cnt_q == '0) : (cnt_q == LAST);
    exp_w    = elem_exp_one(elem_q) ? '1 : '0;
    wr_w     = elem_wr_one(elem_q) ? '1 : '0;
    mismatch = (dout != exp_w);
    if (active) begin
      ram_addr  = cnt_q;
      ram_wdata = wr_w;
      // A failing compare suppresses its paired write.
      ram_we    = (state_q == StWrOnly) || ((state_q == StRdCmpWr) && !mismatch);
    end else begin
      ram_addr  = addr;
      ram_wdata = din;
      ram_we    = wr && !bist_start;
    end
  end

  sp_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AWIDTH(AWIDTH)
  ) u_ram (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(dout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      elem_q    <= E0;
      cnt_q     <= '0;
      bist_busy <= 1'b0;
      bist_done <= 1'b0;
      bist_fail <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (bist_start) begin
            state_q   <= StWrOnly;
            elem_q    <= E0;
            cnt_q     <= '0;
            bist_busy <= 1'b1;
            bist_done <= 1'b0;
            bist_fail <= 1'b0;
            fail_addr <= '0;
            fail_elem <= '0;
          end
        end
        StWrOnly: begin
          if (term) begin
            elem_q  <= E1;
            cnt_q   <= '0;
            state_q <= StRd;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StRd: state_q <= (elem_q == E5) ? StRdCmp : StRdCmpWr;
        StRdCmpWr, StRdCmp: begin
          if (mismatch) begin
            bist_fail <= 1'b1;
            fail_addr <= cnt_q;
            fail_elem <= elem_q;
            bist_busy <= 1'b0;
            bist_done <= 1'b1;
            state_q   <= StDone;
          end else if (term && (elem_q == E5)) begin
            bist_busy <= 1'b0;
            bist_done <= 1'b1;
            state_q   <= StDone;
          end else if (term) begin
            elem_q  <= elem_nxt;
            cnt_q   <= elem_down(elem_nxt) ? LAST : '0;
            state_q <= StRd;
          end else begin
            cnt_q   <= cur_down ? cnt_q - 1'b1 : cnt_q + 1'b1;
            state_q <= StRd;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
